// File: rtl/contador_monitor.sv
// rtl/contador_monitor.sv - passive transition checker for the 4-bit mode counter
// Optional HALT-on-first-mismatch behaviour is enabled by defining CONTADOR_MON_STOP_EN.
module contador_monitor #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cnt_reset,
    input  logic [1:0]           mode,
    input  logic [3:0]           D,
    input  logic [3:0]           Q,
    input  logic                 rco,
    input  logic                 load,
    output logic                 armed,
    output logic [3:0]           exp_q,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
`ifdef CONTADOR_MON_STOP_EN
        HALT  = 2'd2,
`endif
        ARMED = 2'd1
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            exp_val_q, exp_val_d;
    logic                  exp_rco_q, exp_rco_d;
    logic                  exp_load_q, exp_load_d;
    logic                  err_q, err_d;
    logic [2:0]            err_code_q, err_code_d;
    logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;

    logic [3:0]            pred_q;
    logic                  pred_rco;
    logic                  pred_load;
    logic [2:0]            mis;

    // Next-cycle counter outputs predicted from the Q observed right now.
    always_comb begin
        pred_q    = 4'd0;
        pred_rco  = 1'b0;
        pred_load = 1'b0;
        if (!cnt_reset) begin
            case (mode)
                2'b00: begin
                    pred_q   = Q + 4'd1;
                    pred_rco = (Q == 4'hE);
                end
                2'b01: begin
                    pred_q   = Q - 4'd1;
                    pred_rco = (Q == 4'h1);
                end
                2'b10: begin
                    pred_q   = Q + 4'd3;
                    pred_rco = (Q == 4'hC);
                end
                default: begin
                    pred_q    = D;
                    pred_load = 1'b1;
                end
            endcase
        end
    end

    assign mis = {Q != exp_val_q, rco != exp_rco_q, load != exp_load_q};

    always_comb begin
        state_d     = state_q;
        exp_val_d   = exp_val_q;
        exp_rco_d   = exp_rco_q;
        exp_load_d  = exp_load_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        err_count_d = err_count_q;
        case (state_q)
            SYNC: begin
                if (cnt_reset || mode == 2'b11) begin
                    state_d    = ARMED;
                    exp_val_d  = pred_q;
                    exp_rco_d  = pred_rco;
                    exp_load_d = pred_load;
                end
            end
            ARMED: begin
                exp_val_d  = pred_q;
                exp_rco_d  = pred_rco;
                exp_load_d = pred_load;
                if (|mis) begin
                    err_d      = 1'b1;
                    err_code_d = mis;
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERR_CNT_W'(1);
                    end
`ifdef CONTADOR_MON_STOP_EN
                    // Freeze the prediction that failed so it can be inspected.
                    state_d    = HALT;
                    exp_val_d  = exp_val_q;
                    exp_rco_d  = exp_rco_q;
                    exp_load_d = exp_load_q;
`endif
                end
            end
`ifdef CONTADOR_MON_STOP_EN
            HALT: begin
                state_d = HALT;
            end
`endif
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SYNC;
            exp_val_q   <= 4'd0;
            exp_rco_q   <= 1'b0;
            exp_load_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 3'd0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            exp_val_q   <= exp_val_d;
            exp_rco_q   <= exp_rco_d;
            exp_load_q  <= exp_load_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
        end
    end

    assign armed     = (state_q == ARMED);
    assign exp_q     = exp_val_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_contador_monitor.sv
// tb/tb_contador_monitor.sv - directed bench for contador_monitor with a behavioural counter and scoreboard
module tb_contador_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cnt_reset = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] D = 4'd0;
    logic [3:0] Q = 4'd0;
    logic       rco = 1'b0;
    logic       load = 1'b0;
    logic       armed;
    logic [3:0] exp_q;
    logic       err;
    logic [2:0] err_code;
    logic [7:0] err_count;

    contador_monitor #(.ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cnt_reset(cnt_reset), .mode(mode), .D(D),
        .Q(Q), .rco(rco), .load(load), .armed(armed), .exp_q(exp_q),
        .err(err), .err_code(err_code), .err_count(err_count)
    );

    always #5 clk = ~clk;

`ifdef CONTADOR_MON_STOP_EN
    localparam logic [7:0] SAT_EXP = 8'd1;
`else
    localparam logic [7:0] SAT_EXP = 8'd255;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Counter being watched: state and registered outputs.
    logic [3:0] cs = 4'd0;
    logic       crco = 1'b0;
    logic       cload = 1'b0;
    logic       flip_load = 1'b0;

    // Expected monitor state (0 sync, 1 armed, 2 halt).
    int         m_st = 0;
    logic [3:0] m_pq = 4'd0;
    logic       m_prco = 1'b0;
    logic       m_pload = 1'b0;
    logic       m_err = 1'b0;
    logic [2:0] m_code = 3'd0;
    logic [7:0] m_count = 8'd0;

    logic [16:0] sb_q[$];

    function automatic logic [5:0] cnt_next(input logic cr, input logic [1:0] md,
                                            input logic [3:0] d, input logic [3:0] q);
        logic [3:0] n;
        if (cr) return 6'b0;
        case (md)
            2'b00: begin n = q + 4'd1; return {n, n == 4'hF, 1'b0}; end
            2'b01: begin n = q - 4'd1; return {n, n == 4'h0, 1'b0}; end
            2'b10: begin n = q + 4'd3; return {n, n == 4'hF, 1'b0}; end
            default: return {d, 1'b0, 1'b1};
        endcase
    endfunction

    function automatic logic [16:0] observed();
        return {armed, exp_q, err, err_code, err_count};
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pq = 4'd0; m_prco = 1'b0; m_pload = 1'b0;
        m_err = 1'b0; m_code = 3'd0; m_count = 8'd0;
    endtask

    task automatic model_edge(input logic cr, input logic [1:0] md, input logic [3:0] d,
                              input logic [3:0] q, input logic r, input logic l);
        logic [2:0] mm;
        m_err = 1'b0;
        if (m_st == 0) begin
            if (cr || md == 2'b11) begin
                m_st = 1;
                {m_pq, m_prco, m_pload} = cnt_next(cr, md, d, q);
            end
        end else if (m_st == 1) begin
            mm = {q !== m_pq, r !== m_prco, l !== m_pload};
            if (mm != 3'b000) begin
                m_err  = 1'b1;
                m_code = mm;
                if (m_count != 8'hFF) m_count = m_count + 8'd1;
            end
`ifdef CONTADOR_MON_STOP_EN
            if (mm != 3'b000) m_st = 2;
            else {m_pq, m_prco, m_pload} = cnt_next(cr, md, d, q);
`else
            {m_pq, m_prco, m_pload} = cnt_next(cr, md, d, q);
`endif
        end
    endtask

    task automatic step(input logic cr, input logic [1:0] md, input logic [3:0] d);
        @(negedge clk);
        cnt_reset = cr; mode = md; D = d;
        Q = cs; rco = crco; load = cload ^ flip_load;
        model_edge(cr, md, d, Q, rco, load);
        sb_q.push_back({m_st == 1, m_pq, m_err, m_code, m_count});
        {cs, crco, cload} = cnt_next(cr, md, d, cs);
        @(posedge clk);
        #1;
        chk("step", observed(), sb_q.pop_front());
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", observed(), 17'h0);
        @(negedge clk);
        reset = 1'b1;

        // Reset, then count up through the wrap.
        step(1'b1, 2'b00, 4'd0);
        chk("armed_at_reset", {16'd0, armed}, 17'd1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 2'b00, 4'd0);
            chk("cnt_up_exp", {13'd0, exp_q}, 17'((i + 1) % 16));
        end
        step(1'b0, 2'b00, 4'd0);
        chk("cnt_up_errs", {9'd0, err_count}, 17'd0);

        // Load A, +3 twice (wrap 13->0), load C, +3 to F with rco.
        step(1'b0, 2'b11, 4'hA);
        chk("load_a", {13'd0, exp_q}, 17'hA);
        step(1'b0, 2'b10, 4'd0);
        step(1'b0, 2'b10, 4'd0);
        chk("plus3_wrap", {13'd0, exp_q}, 17'h0);
        step(1'b0, 2'b11, 4'hC);
        step(1'b0, 2'b10, 4'd0);
        chk("plus3_to_f", {13'd0, exp_q}, 17'hF);
        step(1'b0, 2'b00, 4'd0);

        // Down-count across zero.
        step(1'b0, 2'b11, 4'h1);
        step(1'b0, 2'b01, 4'd0);
        step(1'b0, 2'b01, 4'd0);
        chk("down_wrap", {13'd0, exp_q}, 17'hF);
        step(1'b0, 2'b00, 4'd0);
        chk("no_err_yet", {9'd0, err_count}, 17'd0);

        // Corrupt Q to 5 where 4 is expected.
        step(1'b0, 2'b11, 4'h3);
        step(1'b0, 2'b00, 4'd0);
        cs = 4'd5;
        step(1'b0, 2'b00, 4'd0);
        chk("fault_err", {13'd0, err, err_code}, 17'b1_100);
        chk("fault_count", {9'd0, err_count}, 17'd1);
        step(1'b0, 2'b00, 4'd0);
        chk("fault_recover", {16'd0, err}, 17'd0);

        // Saturation: wrong load indicator on 300 consecutive edges.
        flip_load = 1'b1;
        for (int i = 0; i < 300; i++) step(1'b0, 2'b00, 4'd0);
        flip_load = 1'b0;
        chk("sat_count", {9'd0, err_count}, {9'd0, SAT_EXP});
        step(1'b0, 2'b00, 4'd0);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset", observed(), 17'h0);
        model_reset();
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 2'b00, 4'd0);
        chk("sync_no_arm", {16'd0, armed}, 17'd0);
        step(1'b0, 2'b11, 4'h7);
        chk("rearm_load", {12'd0, armed, exp_q}, 17'h17);
        step(1'b0, 2'b00, 4'd0);

        // cnt_reset arms even with an unknown mode.
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        step(1'b1, 2'bxx, 4'd0);
        chk("arm_mode_x", {16'd0, armed}, 17'd1);
        step(1'b0, 2'b00, 4'd0);
        step(1'b0, 2'b01, 4'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/contador_monitor.md
# contador_monitor

Passive checker for the 4-bit mode counter. It samples the counter's stimulus (`cnt_reset`, `mode`, `D`) and its outputs (`Q`, `rco`, `load`) on the same clock. It predicts every transition and flags any mismatch. It drives nothing back into the counter; it sits beside the counter in the timing and synthesis benches and is also instantiable in-system as a self-check.

## Interface
Parameters:
- `ERR_CNT_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  shared with the counter; all activity on rising edge.
- `reset`  in  1  asynchronous, active-low; clears the monitor only.
- `cnt_reset`  in  1  counter's synchronous active-high reset, as presented to the counter.
- `mode`  in  2  counter mode: 00 +1, 01 −1, 10 +3, 11 load `D`.
- `D`  in  4  counter load data.
- `Q`  in  4  counter output.
- `rco`  in  1  counter ripple-carry output.
- `load`  in  1  counter load indicator.
- `armed`  out  1  monitor synchronised; checks are active.
- `exp_q`  out  4  value of `Q` expected at the next edge.
- `err`  out  1  one-cycle pulse per mismatching check.
- `err_code`  out  3  {q_mis, rco_mis, load_mis} of the last failing check; holds until the next failure.
- `err_count`  out  `ERR_CNT_W`  failing checks, saturating at all-ones.

## Operation
- States: SYNC (no checks), ARMED (check every edge), HALT (only when `CONTADOR_MON_STOP_EN` is defined).
- Prediction at each edge, computed from the stimulus sampled at that edge and the `Q` observed at that edge. Rules are in priority order:
  - `cnt_reset`=1 → exp Q=0, rco=0, load=0, regardless of mode.
  - mode 00 → Q+1 mod 16; rco=1 iff the result is 15; load=0.
  - mode 01 → Q−1 mod 16; rco=1 iff the result is 0; load=0.
  - mode 10 → Q+3 mod 16, 4-bit truncation; rco=1 iff the result is 15; load=0.
  - mode 11 → Q=D, rco=0, load=1.
- Each prediction is registered into `exp_q`, `exp_rco` and `exp_load`, then compared with `Q`, `rco` and `load` at the following edge.
- Prediction uses the observed `Q`, not a private model. A single corrupted value therefore yields exactly one failing check, and the next transition is checked from the corrupted value.
- SYNC → ARMED at the first edge sampling `cnt_reset`=1 or mode=11. That edge's prediction is the first one checked.
- In ARMED, every edge compares first and then re-predicts. On any mismatch:
  - `err`=1 for the following cycle;
  - `err_code` is loaded;
  - `err_count` increments, saturating.
- The `enable` input of the counter has no effect on the counter and is not monitored.
- Reset values: state SYNC, `armed`=0, `exp_q`=0, `err`=0, `err_code`=0, `err_count`=0.

## Timing
- Stimulus sampled at edge N; counter output checked at edge N+1; `err` visible from N+1 until N+2.
- `armed` rises at the arming edge N. The first `err` can appear only after edge N+1.
- Asynchronous `reset` asserted mid-operation:
  - all outputs clear immediately, and any pending prediction is discarded;
  - after release, the monitor stays in SYNC until the next `cnt_reset`=1 or mode=11 sample.
- Back-to-back errors give back-to-back `err` pulses, with one count per edge.
- `cnt_reset` sampled while in SYNC arms the monitor even if `mode` is X.

## Configuration
- `CONTADOR_MON_STOP_EN` defined:
  - first mismatch moves ARMED → HALT;
  - in HALT, `err_code`, `exp_q` and `err_count` freeze, `err` stays 0, and `armed`=0;
  - exit from HALT is only by `reset`.
- Not defined: the HALT state does not exist, and the monitor keeps checking and counting indefinitely.

## Test plan
- Reset/count-up: `cnt_reset` for 1 edge, then mode 00 for 16 edges.
  - Required: `armed`=1 from the reset edge; Q follows 1..15,0; rco=1 only at Q=15; `err_count`=0.
- Load and +3 wrap: mode 11 with D=4'hA → load=1, Q=A. Then mode 10 → Q=D, then Q=0 (13+3 wraps), rco=0. Then load C and step +3 → Q=F, rco=1.
- Down-count boundary: from Q=1, mode 01 → Q=0, rco=1. Next step → Q=F, rco=0. `err` is never asserted.
- Fault injection: force Q=5 where 4 is expected.
  - Required: `err` pulses once, `err_code`=3'b100, `err_count`=1.
  - Release the force; the next +1 to 6 passes.
  - With `CONTADOR_MON_STOP_EN`: HALT is entered and a later forced error leaves `err_count`=1.
- Saturation: inject 300 consecutive mismatches → `err_count`=255, with `err` high on each of the 300 cycles.
- Reset mid-operation: pulse `reset` low between edges while ARMED.
  - Required: outputs are 0 within the same cycle.
  - Mode 00 edges produce no checks; `armed` returns only after a mode 11 sample.
